// File: rtl/switch_debouncer.sv
// switch_debouncer
//   Synchronizes and debounces N_CH raw board switch inputs. Each channel has its
//   own 4-state FSM and stability counter; a level change is accepted only after
//   DEBOUNCE_CYCLES consecutive cycles of the new level at the synchronizer output.
//
// Ports
//   clk       sole clock, rising edge
//   rst_n     asynchronous active-low reset
//   sw_raw    raw asynchronous switch levels            [N_CH-1:0]
//   sw_clean  debounced registered levels                [N_CH-1:0]
//   rise      one-cycle strobe on sw_clean 0->1          [N_CH-1:0]
//   fall      one-cycle strobe on sw_clean 1->0          [N_CH-1:0]
//   changed   OR of rise|fall, same cycle
//
// Configuration
//   SWITCH_DEBOUNCER_SYNC3_EN  defined: 3-flop synchronizer (+1 cycle latency)
//                              undefined: 2-flop synchronizer
module switch_debouncer #(
  parameter int unsigned N_CH            = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] sw_raw,
  output logic [N_CH-1:0] sw_clean,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            changed
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StStableLo,
    StWaitHi,
    StStableHi,
    StWaitLo
  } state_e;

  // Synchronizer
  logic [N_CH-1:0] sync1_q, sync2_q;
  logic [N_CH-1:0] sample;

`ifdef SWITCH_DEBOUNCER_SYNC3_EN
  logic [N_CH-1:0] sync3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign sample = sync3_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
    end
  end

  assign sample = sync2_q;
`endif

  // Per-channel FSM and counter
  state_e          state_q [N_CH];
  state_e          state_d [N_CH];
  logic [CntW-1:0] cnt_q   [N_CH];
  logic [CntW-1:0] cnt_d   [N_CH];

  logic [N_CH-1:0] sw_clean_q, sw_clean_d;
  logic [N_CH-1:0] rise_q, rise_d;
  logic [N_CH-1:0] fall_q, fall_d;
  logic            changed_q, changed_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= StStableLo;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Next-state logic; count is cleared both on glitch rejection and on acceptance
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        StStableLo: begin
          cnt_d[i] = '0;
          if (sample[i]) begin
            state_d[i] = StWaitHi;
            cnt_d[i]   = CntW'(1);
          end
        end
        StWaitHi: begin
          if (!sample[i]) begin
            state_d[i] = StStableLo;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntMax) begin
            state_d[i] = StStableHi;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
          end
        end
        StStableHi: begin
          cnt_d[i] = '0;
          if (!sample[i]) begin
            state_d[i] = StWaitLo;
            cnt_d[i]   = CntW'(1);
          end
        end
        StWaitLo: begin
          if (sample[i]) begin
            state_d[i] = StStableHi;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntMax) begin
            state_d[i] = StStableLo;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
          end
        end
      endcase
    end
  end

  // Output logic: strobes fire on the acceptance transition and are registered
  // together with sw_clean so all of them change in the same cycle.
  always_comb begin
    sw_clean_d = sw_clean_q;
    rise_d     = '0;
    fall_d     = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (state_q[i] == StWaitHi && sample[i] && cnt_q[i] == CntMax) begin
        sw_clean_d[i] = 1'b1;
        rise_d[i]     = 1'b1;
      end
      if (state_q[i] == StWaitLo && !sample[i] && cnt_q[i] == CntMax) begin
        sw_clean_d[i] = 1'b0;
        fall_d[i]     = 1'b1;
      end
    end
    changed_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_clean_q <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      changed_q  <= 1'b0;
    end else begin
      sw_clean_q <= sw_clean_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      changed_q  <= changed_d;
    end
  end

  assign sw_clean = sw_clean_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign changed  = changed_q;

endmodule

// File: tb/tb_switch_debouncer.sv
module tb_switch_debouncer;

  localparam int unsigned NCh = 4;
  localparam int unsigned Deb = 16;
`ifdef SWITCH_DEBOUNCER_SYNC3_EN
  localparam int Lat = 3 + Deb;
`else
  // Drive after edge c: capture at c+1, sync2 at c+2, accept at c+2+Deb.
  localparam int Lat = 2 + Deb;
`endif

  logic           clk;
  logic           rst_n;
  logic [NCh-1:0] sw_raw;
  logic [NCh-1:0] sw_clean;
  logic [NCh-1:0] rise;
  logic [NCh-1:0] fall;
  logic           changed;

  switch_debouncer #(
    .N_CH           (NCh),
    .DEBOUNCE_CYCLES(Deb)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw_raw  (sw_raw),
    .sw_clean(sw_clean),
    .rise    (rise),
    .fall    (fall),
    .changed (changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int             cyc;
    logic [NCh-1:0] r;
    logic [NCh-1:0] f;
  } exp_t;

  exp_t           exp_q[$];
  logic [NCh-1:0] clean_m;
  int             cyc;
  int             n_assert;
  int             n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic push(input logic [NCh-1:0] r, input logic [NCh-1:0] f);
    exp_t e;
    e.cyc = cyc + Lat;
    e.r   = r;
    e.f   = f;
    exp_q.push_back(e);
  endtask

  // One clock; outputs sampled 1 time unit after the edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      check("rise", rise, e.r);
      check("fall", fall, e.f);
      check("changed", changed, 32'(|(e.r | e.f)));
      clean_m = (clean_m | e.r) & ~e.f;
    end else begin
      check("rise_idle", rise, 0);
      check("fall_idle", fall, 0);
      check("changed_idle", changed, 0);
    end
    check("sw_clean", sw_clean, clean_m);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    cyc      = 0;
    n_assert = 0;
    n_fail   = 0;
    clean_m  = '0;
    rst_n    = 1'b0;
    sw_raw   = '0;
    #1;
    check("reset_clean", sw_clean, 0);
    check("reset_rise", rise, 0);
    check("reset_fall", fall, 0);
    check("reset_changed", changed, 0);
    run(3);
    rst_n = 1'b1;

    // Quiet inputs: nothing may assert.
    run(40);

    // Single rise on channel 0.
    sw_raw = 4'b0001;
    push(4'b0001, 4'b0000);
    run(25);

    // Glitch on channel 2 shorter than the debounce window.
    sw_raw = 4'b0101;
    run(10);
    sw_raw = 4'b0001;
    run(30);

    // Bounce on channel 1 every 3 cycles, then settle high.
    for (int k = 0; k < 10; k++) begin
      sw_raw[1] = ~sw_raw[1];
      run(3);
    end
    sw_raw[1] = 1'b1;
    push(4'b0010, 4'b0000);
    run(25);

    // Both high channels fall together.
    sw_raw = 4'b0000;
    push(4'b0000, 4'b0011);
    run(25);

    // Simultaneous rise and fall on all channels.
    sw_raw = 4'b1111;
    push(4'b1111, 4'b0000);
    run(25);
    sw_raw = 4'b0000;
    push(4'b0000, 4'b1111);
    run(25);

    // Async reset in the middle of a channel-3 debounce while channel 0 is high.
    sw_raw = 4'b0001;
    push(4'b0001, 4'b0000);
    run(25);
    sw_raw = 4'b1001;
    run(11);
    rst_n = 1'b0;
    #1;
    check("async_clean", sw_clean, 0);
    check("async_rise", rise, 0);
    check("async_changed", changed, 0);
    clean_m = '0;
    run(3);
    rst_n = 1'b0;
    rst_n = 1'b1;
    push(4'b1001, 4'b0000);
    run(25);

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Input-conditioning stage that sits directly upstream of the combinational logic-expression block. It takes four raw, asynchronous board switch/button signals, synchronizes them into the single clock domain, and debounces each channel independently. It drives the clean levels that become that block's `a`, `b`, `c` and `d` inputs. Per-channel rise/fall strobes are also provided for event-driven consumers.

## Interface
Parameters:
- `N_CH`, default 4: number of independent channels; bit 3..0 map to `d`,`c`,`b`,`a` downstream.
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required before a level change is accepted; legal range ≥ 2.
- Counter width is derived as `$clog2(DEBOUNCE_CYCLES)`; it is not a parameter.

Ports:
- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset; assertion takes effect immediately, release is synchronous to `clk` at board level.
- `sw_raw`  input  N_CH  raw asynchronous switch levels.
- `sw_clean`  output  N_CH  debounced, registered levels.
- `rise`  output  N_CH  one-cycle strobe, set in the cycle `sw_clean[i]` goes 0→1.
- `fall`  output  N_CH  one-cycle strobe, set in the cycle `sw_clean[i]` goes 1→0.
- `changed`  output  1  OR-reduction of `rise | fall`, registered alongside them.

## Operation
- Per-channel synchronizer:
  - 2 flops `sync1 → sync2`; `sync2[i]` is the synchronized sample.
  - No combinational path from `sw_raw` to any output.
- Per-channel FSM, 4 states:
  - STABLE_LO: `sw_clean=0`, counter held at 0. `sync2=1` → WAIT_HI with counter=1.
  - WAIT_HI: `sync2=0` → STABLE_LO, counter=0 (glitch rejected). `sync2=1` and counter==DEBOUNCE_CYCLES-1 → STABLE_HI, `sw_clean←1`, `rise←1`, counter=0. Otherwise counter+1.
  - STABLE_HI, WAIT_LO: mirror of the above with polarity inverted; exit to STABLE_LO drives `fall←1`.
- Counter arithmetic:
  - Saturation is never reached; the counter is compared against DEBOUNCE_CYCLES-1 and cleared on acceptance.
  - Wrap-around is impossible by construction.
- Channels are fully independent. Simultaneous acceptance on several channels sets several `rise`/`fall` bits in the same cycle; `changed` is 1 once.
- `rise`, `fall` and `changed` are registered and cleared the cycle after they assert. A strobe lasts exactly one cycle even if the input keeps toggling afterwards.
- Reset values:
  - `sync1`, `sync2`, `sw_clean`, `rise`, `fall`, `changed` = 0.
  - All counters = 0; all FSMs in STABLE_LO.
- Reset mid-debounce discards the partial count. A switch held high through reset release is accepted as a normal rise.

## Timing
- Let edge 0 be the first `clk` edge that samples a new raw level into `sync1`; `sync2` shows it at edge 1.
- `sw_clean` and its strobe update at edge 1 + DEBOUNCE_CYCLES. With defaults that is edge 17, i.e. 17 cycles after capture, about 18 cycles of raw hold.
- A raw pulse shorter than DEBOUNCE_CYCLES cycles at `sync2` never changes `sw_clean`.
- Minimum accepted toggle period per channel is 2×DEBOUNCE_CYCLES cycles.
- `rise`/`fall` are coincident with the `sw_clean` edge, in the same cycle; `changed` is also in that same cycle.
- Downstream combinational outputs settle within the cycle in which `sw_clean` changes.

## Configuration
- Macro: `SWITCH_DEBOUNCER_SYNC3_EN`.
- Defined: synchronizer is 3 flops (`sync1 → sync2 → sync3`), and the FSM samples `sync3`. All latencies in Timing increase by exactly 1 cycle; reset value of the extra flop is 0.
- Undefined: 2-flop synchronizer as specified above.

## Test plan
- Reset, then `sw_raw=4'b0000` held for 40 cycles → `sw_clean=0`; `rise`, `fall` and `changed` never assert.
- `sw_raw[0]` 0→1 and held, DEBOUNCE_CYCLES=16 → `sw_clean[0]=1` and `rise[0]=1` at edge 17 after capture; `rise[0]=0` at edge 18; other bits unchanged.
- Glitch: `sw_raw[2]=1` for 10 cycles, then 0 → `sw_clean[2]` stays 0, no strobe, counter back to 0.
- Bounce: `sw_raw[1]` toggles every 3 cycles for 30 cycles, then holds 1 → exactly one `rise[1]`, occurring 17 edges after the final stable capture.
- Simultaneous: `sw_raw` 0000→1111 on one edge → all four `rise` bits high in the same cycle; `changed=1` for one cycle. Later 1111→0000 produces four `fall` bits together.
- Async reset: `rst_n` pulsed low mid-WAIT_HI (count 9) on channel 3 with `sw_raw[3]` still 1 → outputs 0 immediately. After release, `rise[3]` appears 17 edges after re-capture, with no early acceptance.
